sixtyfour_bit_subtractor_seq: RTL and testbench
===============================================

# sixtyfour_bit_subtractor_seq

Multi-cycle 64-bit subtractor that computes D = A − B − Bin one slice per clock and reports the final borrow and signed overflow. It is the inverse-direction companion to the team's combinational 64-bit ripple adder. It trades latency for a short carry/borrow chain. It uses a start/busy/done handshake so a controller or bench can issue operations back to back.

## Interface

**Parameters**
- `SLICE_W`, default 16: bits processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64; other values are rejected at elaboration. N = 64/SLICE_W is the number of slices.

**Ports**
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation. Sampled on `clk`.
- `A` input 64: minuend. Captured when `start` is accepted.
- `B` input 64: subtrahend. Captured when `start` is accepted.
- `Bin` input 1: borrow-in. Captured when `start` is accepted.
- `busy` output 1: high while slices are being processed.
- `done` output 1: one-cycle pulse when a result is committed.
- `D` output 64: difference.
- `Bout` output 1: borrow-out. It is 1 iff A < B + Bin, unsigned.
- `V` output 1: signed overflow. V = (A[63] ≠ B[63]) & (D[63] ≠ A[63]).

## Operation

**States**
- IDLE: waiting for `start`.
- RUN: processing slices.
- DONE: result just committed.

**Accept**
- When `start`=1 in IDLE or DONE, the following are captured into working registers at that edge:
  - A and B
  - Bin, as the running borrow
  - slice index 0
- The state then goes to RUN.
- `start` in RUN is ignored. The operands in flight are not disturbed.

**RUN**
- Each edge processes slice i: bits [i·SLICE_W +: SLICE_W].
- Working difference slice = A_slice − B_slice − borrow, modulo 2^SLICE_W.
- The running borrow becomes 1 iff A_slice < B_slice + borrow.
- The index increments.
- On the edge that processes slice N−1:
  - `D`, `Bout` and `V` are loaded from the working registers and final borrow.
  - The state goes to DONE.

**DONE**
- Lasts exactly one cycle.
- The next state is RUN if `start`=1, otherwise IDLE.

**Output holding**
- `D`, `Bout` and `V` change only at a commit edge.
- They hold the previous result through IDLE, RUN and DONE.
- Partial slices are never visible on `D`.

**Output decode**
- `busy` = (state == RUN).
- `done` = (state == DONE).

**Arithmetic**
- All arithmetic is unsigned modulo 2^64.
- A = B with Bin = 1 gives D = all ones, Bout = 1.

## Timing

**Reset**
- On `rst`=1, immediately and independent of `clk`:
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `D` = 0, `Bout` = 0, `V` = 0
  - working registers cleared
- Reset asserted mid-RUN aborts the operation. No `done` is produced and the outputs read 0.
- The first edge after `rst` deasserts may accept `start`.

**Latency**
- `start` is accepted at edge k.
- `busy` is high from after edge k to after edge k+N.
- The result commits at edge k+N. `done` is high for the cycle between edges k+N and k+N+1.
- With SLICE_W=16, N=4: the commit occurs 4 edges after acceptance.

**Back-to-back issue**
- If `start` is high during the DONE cycle, the new operation is accepted at edge k+N+1.
- The next result commits at edge k+2N+1. The gap between operations is one cycle.

**SLICE_W=64**
- N=1: RUN lasts one cycle, and commit occurs at the first edge after acceptance.

**Hold requirements**
- Inputs A, B and Bin need only be stable at the accepting edge.
- `start` held high continuously re-issues the current A/B/Bin at every accept point.

## Test plan

1. **Basic subtraction.** A=5, B=3, Bin=0, SLICE_W=16.
   - Required: D=2, Bout=0, V=0.
   - `busy` high exactly 4 cycles; `done` pulses once, 4 edges after the accept edge.
2. **Underflow.** A=0, B=1, Bin=0.
   - Required: D=0xFFFF_FFFF_FFFF_FFFF, Bout=1, V=0.
   - Also A=B=0x1234, Bin=1: D=all ones, Bout=1.
3. **Signed overflow.** A=0x8000_0000_0000_0000, B=1, Bin=0.
   - Required: D=0x7FFF_FFFF_FFFF_FFFF, Bout=0, V=1.
4. **Cross-slice borrow ripple.** A=0x0001_0000_0000_0000, B=0, Bin=1.
   - Required: D=0x0000_FFFF_FFFF_FFFF, Bout=0.
   - Repeat with SLICE_W=1, 8, 64 for an identical result; latency must be N.
5. **Handshake.**
   - Issue A=10, B=4. While `busy`, drive `start`=1 with A=99, B=1. Required: first result D=6; the second request is ignored; `D` does not change during RUN.
   - Then `start` during DONE with A=7, B=7. Required: accepted, next commit D=0 exactly N+1 edges after the prior commit.
6. **Reset mid-operation.** Pulse `rst` between clock edges during RUN slice 2.
   - Required: `busy`, `done`, `D`, `Bout` and `V` all go to 0 immediately, and no `done` follows.
   - A subsequent A=0xFFFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFE must give D=1, Bout=0.

Source files
------------

// File: rtl/sixtyfour_bit_subtractor_seq.sv
// Multi-cycle 64-bit subtractor: D = A - B - Bin, one SLICE_W-bit slice per
// clock, with start/busy/done handshake. Results (D, Bout, V) change only at
// the commit edge; partial slices never appear on the outputs.
module sixtyfour_bit_subtractor_seq #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Bin,
  output logic        busy,
  output logic        done,
  output logic [63:0] D,
  output logic        Bout,
  output logic        V
);

  localparam int N = 64 / SLICE_W;
  localparam logic [5:0] LAST_IDX = 6'(N - 1);

  generate
    if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 || SLICE_W == 8 ||
          SLICE_W == 16 || SLICE_W == 32 || SLICE_W == 64)) begin : g_bad_slice_w
      $error("SLICE_W must be one of 1, 2, 4, 8, 16, 32, 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic                 accept_s;
  logic                 last_s;

  logic [63:0]          a_r;
  logic [63:0]          b_r;
  logic [63:0]          diff_r;
  logic                 borrow_r;
  logic [5:0]           idx_r;

  logic [5:0]           base_s;
  logic [SLICE_W-1:0]   a_slice_s;
  logic [SLICE_W-1:0]   b_slice_s;
  logic [SLICE_W:0]     sub_s;
  logic                 borrow_next_s;
  logic [63:0]          diff_full_s;
  logic                 v_s;

  // Next-state decode and accept qualification (start ignored while running).
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = (idx_r == LAST_IDX);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == S_RUN);
      done    <= (state_next_s == S_DONE);
    end
  end

  // Current slice subtraction; the extra top bit of sub_s is the slice borrow.
  always_comb begin
    base_s        = idx_r * 6'(SLICE_W);
    a_slice_s     = SLICE_W'(a_r >> base_s);
    b_slice_s     = SLICE_W'(b_r >> base_s);
    sub_s         = {1'b0, a_slice_s} - {1'b0, b_slice_s} - {{SLICE_W{1'b0}}, borrow_r};
    borrow_next_s = sub_s[SLICE_W];
    // Unprocessed slices of diff_r are zero, so OR-ing in the new slice is exact.
    diff_full_s   = diff_r | (64'(sub_s[SLICE_W-1:0]) << base_s);
    v_s           = (a_r[63] ^ b_r[63]) & (diff_full_s[63] ^ a_r[63]);
  end

  // Working registers and committed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= 64'd0;
      b_r      <= 64'd0;
      diff_r   <= 64'd0;
      borrow_r <= 1'b0;
      idx_r    <= 6'd0;
      D        <= 64'd0;
      Bout     <= 1'b0;
      V        <= 1'b0;
    end else if (accept_s) begin
      a_r      <= A;
      b_r      <= B;
      diff_r   <= 64'd0;
      borrow_r <= Bin;
      idx_r    <= 6'd0;
    end else if (state_r == S_RUN) begin
      diff_r   <= diff_full_s;
      borrow_r <= borrow_next_s;
      idx_r    <= idx_r + 6'd1;
      if (last_s) begin
        D    <= diff_full_s;
        Bout <= borrow_next_s;
        V    <= v_s;
      end else begin
        D    <= D;
        Bout <= Bout;
        V    <= V;
      end
    end else begin
      a_r      <= a_r;
      b_r      <= b_r;
    end
  end

endmodule

// File: tb/tb_sixtyfour_bit_subtractor_seq.sv
// Self-checking bench: four instances (SLICE_W = 16, 1, 8, 64) share one
// stimulus stream; each is checked every cycle against a transaction-level
// model, plus literal expectations for the directed cases.
module tb_sixtyfour_bit_subtractor_seq;

  localparam int NI = 4;
  localparam int WS [NI] = '{16, 1, 8, 64};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] A = 64'd0;
  logic [63:0] B = 64'd0;
  logic        Bin = 1'b0;

  logic        busy_a [NI];
  logic        done_a [NI];
  logic [63:0] d_a    [NI];
  logic        bout_a [NI];
  logic        v_a    [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      sixtyfour_bit_subtractor_seq #(.SLICE_W(WS[gi])) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy_a[gi]),
        .done  (done_a[gi]),
        .D     (d_a[gi]),
        .Bout  (bout_a[gi]),
        .V     (v_a[gi])
      );
    end
  endgenerate

  // Reference: unsigned 65-bit difference for D/Bout, true signed result for V.
  function automatic logic [65:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                          input logic bi);
    logic [64:0]        u;
    logic signed [65:0] s;
    logic               ov;
    u  = {1'b0, a} - {1'b0, b} - {64'd0, bi};
    s  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}) - $signed({65'd0, bi});
    ov = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
    return {ov, u[64], u[63:0]};
  endfunction

  // Transaction model: cycles remaining per instance, pending and committed result.
  int          rem    [NI];
  logic [65:0] pend   [NI];
  logic [65:0] m_res  [NI];
  logic        m_done [NI];

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        rem[g]    <= 0;
        pend[g]   <= 66'd0;
        m_res[g]  <= 66'd0;
        m_done[g] <= 1'b0;
      end else if (rem[g] > 0) begin
        rem[g] <= rem[g] - 1;
        if (rem[g] == 1) begin
          m_res[g]  <= pend[g];
          m_done[g] <= 1'b1;
        end else begin
          m_done[g] <= 1'b0;
        end
      end else begin
        m_done[g] <= 1'b0;
        if (start) begin
          pend[g] <= ref_sub(A, B, Bin);
          rem[g]  <= 64 / WS[g];
        end
      end
    end
  end

  task automatic cmp(input string nm, input int g, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d (SLICE_W=%0d) actual=%h required=%h t=%0t",
               nm, g, WS[g], act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NI; g++) begin
        cmp("busy", g, 64'(busy_a[g]), 64'(rem[g] > 0));
        cmp("done", g, 64'(done_a[g]), 64'(m_done[g]));
        cmp("D",    g, d_a[g], m_res[g][63:0]);
        cmp("Bout", g, 64'(bout_a[g]), 64'(m_res[g][64]));
        cmp("V",    g, 64'(v_a[g]), 64'(m_res[g][65]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic all_zero(input string nm);
    for (int g = 0; g < NI; g++) begin
      cmp({nm, "_busy"}, g, 64'(busy_a[g]), 64'd0);
      cmp({nm, "_done"}, g, 64'(done_a[g]), 64'd0);
      cmp({nm, "_D"},    g, d_a[g], 64'd0);
      cmp({nm, "_Bout"}, g, 64'(bout_a[g]), 64'd0);
      cmp({nm, "_V"},    g, 64'(v_a[g]), 64'd0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a[0] || busy_a[1] || busy_a[2] || busy_a[3]) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) cmp("idle_timeout", 0, 64'd1, 64'd0);
  endtask

  // Issue one op, check SLICE_W=16 latency, then literal results on all widths.
  task automatic issue(input string nm, input logic [63:0] a, input logic [63:0] b,
                       input logic bi, input logic [63:0] ed, input logic eb,
                       input logic ev);
    int cnt;
    step();
    start = 1'b1; A = a; B = b; Bin = bi;
    step();
    start = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      step();
      cnt++;
      if (done_a[0]) break;
    end
    cmp({nm, "_latency"}, 0, 64'(cnt), 64'd4);
    wait_idle();
    for (int g = 0; g < NI; g++) begin
      cmp({nm, "_D"},    g, d_a[g], ed);
      cmp({nm, "_Bout"}, g, 64'(bout_a[g]), 64'(eb));
      cmp({nm, "_V"},    g, 64'(v_a[g]), 64'(ev));
    end
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    all_zero("reset");
    rst = 1'b0;

    // Directed cases
    issue("basic",    64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0);
    issue("underflow", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    issue("eq_bin",   64'h1234, 64'h1234, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    issue("ovf",      64'h8000_0000_0000_0000, 64'd1, 1'b0,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    issue("ripple",   64'h0001_0000_0000_0000, 64'd0, 1'b1,
          64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // Handshake: start ignored during RUN, accepted during DONE (SLICE_W=16 timeline)
    step();
    start = 1'b1; A = 64'd10; B = 64'd4; Bin = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c >= 1 && c <= 4) cmp("hs_hold_D", 0, d_a[0], 64'h0000_FFFF_FFFF_FFFF);
      if (c == 5) begin
        cmp("hs_done1", 0, 64'(done_a[0]), 64'd1);
        cmp("hs_D1",    0, d_a[0], 64'd6);
      end
      if (c == 9) cmp("hs_nodone", 0, 64'(done_a[0]), 64'd0);
      if (c == 10) begin
        cmp("hs_done2", 0, 64'(done_a[0]), 64'd1);
        cmp("hs_D2",    0, d_a[0], 64'd0);
      end
      if (c <= 3) begin
        start = 1'b1; A = 64'd99; B = 64'd1;
      end else if (c == 5) begin
        start = 1'b1; A = 64'd7; B = 64'd7;
      end else begin
        start = 1'b0;
      end
    end
    wait_idle();

    // Reset in the middle of RUN (before slice 2 of SLICE_W=16 is processed)
    step();
    start = 1'b1; A = 64'hDEAD_BEEF_0123_4567; B = 64'h1111; Bin = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    all_zero("midrst");
    #1;
    rst = 1'b0;
    repeat (6) step();
    issue("post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0,
          64'd1, 1'b0, 1'b0);

    // Randomised traffic, checked cycle by cycle by the model
    for (int i = 0; i < 600; i++) begin
      step();
      start = ($urandom_range(2) == 0);
      Bin = 1'($urandom_range(1));
      A = {$urandom, $urandom};
      case ($urandom_range(3))
        0: B = {$urandom, $urandom};
        1: B = A;
        2: B = A + 64'($urandom_range(3));
        default: begin
          A = {1'($urandom_range(1)), 63'd0};
          B = {1'($urandom_range(1)), {63{1'($urandom_range(1))}}};
        end
      endcase
    end
    step();
    start = 1'b0;
    wait_idle();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
